// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, buffers returned words in a small FIFO and hands them
// to decode with valid/stall flow control. A redirect flushes in-flight work.
module fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_1000,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [31:0]       if_instruction,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;

  logic [31:0]       buf_data [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              handshake;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_target;
  logic              unused_low_bits;

  assign full            = (count == CNT_W'(BUF_DEPTH));
  assign empty           = (count == '0);
  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  // A request is only in flight outside IDLE, so in IDLE the outstanding
  // count is zero and issue gating reduces to "FIFO has a free slot".
  // Reset gates the request off combinationally so nothing is issued while
  // the block is held in reset.
  assign imem_req_valid = reset && (state == IDLE) && !full;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  // A redirect kills the response of the current request and any pop.
  assign push = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop  = !empty && !stall && !redirect_valid;

  assign if_valid       = !empty;
  assign if_instruction = empty ? 32'h0 : buf_data[rd_ptr];
  assign if_pc          = empty ? '0 : buf_pc[rd_ptr];

  // Request FSM: IDLE issues, WAIT collects the response, DRAIN swallows a
  // response whose request was overtaken by a redirect. A response seen in
  // DRAIN always returns to IDLE, even alongside a fresh redirect, because
  // that response is the only one that will ever come back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            req_pc <= pc;
            state  <= redirect_valid ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid)      state <= IDLE;
          else if (redirect_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (imem_rsp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch PC: redirect target wins, otherwise advance one word per accepted
  // request (wraps naturally at the address width).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (handshake) begin
      pc <= pc + ADDR_W'(4);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: the word travels together with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

  // Issue gating must make a push onto a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// redirect/reset sequences and a randomized run against a stream model.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;

  // memory model state: one pending request with a countdown
  bit          mem_pending = 0;
  logic [31:0] mem_addr = 0;
  int          mem_timer = 0;
  int          mem_lat = 1;

  // stream model state for the randomized phase
  bit          model_on = 0;
  bit          prev_redir = 0;
  logic [31:0] exp_fetch = 32'h1000;
  logic [31:0] exp_del = 32'h1000;
  int          delivered = 0;

  typedef struct {
    bit          rst;
    bit          st;
    bit          rdy;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add_vec(bit rst, bit st, bit rdy, bit rv, logic [31:0] a, bit iv, logic [31:0] p);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.exp_rv = rv;
    v.exp_addr = a; v.exp_iv = iv; v.exp_pc = p;
    vecs.push_back(v);
  endfunction

  // Drive inputs for this cycle (called just after the rising edge).
  task automatic apply_stimulus(input bit st, input bit rdy, input bit rv, input logic [31:0] rpc);
    stall          = st;
    imem_req_ready = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rsp_valid = mem_pending && (mem_timer == 0);
    imem_rsp_data  = imem_rsp_valid ? (mem_addr ^ K) : $urandom;
    #1;
  endtask

  task automatic check_output(input string tag, input bit rv, input logic [31:0] a, input bit iv, input logic [31:0] p);
    check_val({tag, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, rv});
    if (rv) check_val({tag, "_req_addr"}, imem_req_addr, a);
    check_val({tag, "_if_valid"}, {31'b0, if_valid}, {31'b0, iv});
    check_val({tag, "_if_pc"}, if_pc, iv ? p : 32'h0);
    check_val({tag, "_if_instr"}, if_instruction, iv ? (p ^ K) : 32'h0);
  endtask

  // Observe the upcoming edge: model checks, memory bookkeeping, advance.
  task automatic end_cycle();
    bit hs;
    bit rsp_now;
    hs      = imem_req_valid && imem_req_ready;
    rsp_now = imem_rsp_valid;
    if (hs) check_val("one_outstanding", {31'b0, mem_pending}, 32'h0);
    if (model_on) begin
      if (hs) begin
        check_val("fetch_addr", imem_req_addr, exp_fetch);
        exp_fetch += 4;
      end
      if (prev_redir) check_val("flush_valid", {31'b0, if_valid}, 32'h0);
      if (!if_valid) check_val("empty_pc", if_pc, 32'h0);
      if (if_valid && !stall && !redirect_valid) begin
        check_val("deliver_pc", if_pc, exp_del);
        check_val("deliver_instr", if_instruction, exp_del ^ K);
        exp_del += 4;
        delivered++;
      end
      if (redirect_valid) begin
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        exp_del   = redirect_pc & 32'hFFFF_FFFC;
      end
      prev_redir = redirect_valid;
    end
    if (rsp_now) mem_pending = 0;
    else if (mem_pending && mem_timer > 0) mem_timer--;
    if (hs) begin
      if (model_on) mem_lat = $urandom_range(1, 3);
      mem_pending = 1;
      mem_addr    = imem_req_addr;
      mem_timer   = mem_lat - 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Hold reset, check outputs are cleared, release just after an edge.
  task automatic do_reset();
    reset = 1'b0;
    stall = 0; imem_req_ready = 0; redirect_valid = 0; redirect_pc = 0;
    imem_rsp_valid = 0;
    mem_pending = 0; mem_lat = 1; prev_redir = 0;
    #3;
    check_val("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_val("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check_val("rst_if_pc", if_pc, 32'h0);
    check_val("rst_if_instr", if_instruction, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // streaming with 1-cycle memory
    add_vec(1, 0, 1, 1, 32'h1000, 0, 0);
    add_vec(0, 0, 1, 0, 0,        0, 0);
    add_vec(0, 0, 1, 1, 32'h1004, 1, 32'h1000);
    add_vec(0, 0, 1, 0, 0,        0, 0);
    add_vec(0, 0, 1, 1, 32'h1008, 1, 32'h1004);
    add_vec(0, 0, 1, 0, 0,        0, 0);
    add_vec(0, 0, 1, 1, 32'h100C, 1, 32'h1008);
    // stall fills the FIFO, then releases in order
    add_vec(1, 1, 1, 1, 32'h1000, 0, 0);
    add_vec(0, 1, 1, 0, 0,        0, 0);
    add_vec(0, 1, 1, 1, 32'h1004, 1, 32'h1000);
    add_vec(0, 1, 1, 0, 0,        1, 32'h1000);
    for (int i = 0; i < 6; i++) add_vec(0, 1, 1, 0, 0, 1, 32'h1000);
    add_vec(0, 0, 1, 0, 0,        1, 32'h1000);
    add_vec(0, 0, 1, 1, 32'h1008, 1, 32'h1004);
    add_vec(0, 0, 1, 0, 0,        0, 0);
    add_vec(0, 0, 1, 1, 32'h100C, 1, 32'h1008);
    // memory not ready: address held until the handshake
    add_vec(1, 0, 0, 1, 32'h1000, 0, 0);
    add_vec(0, 0, 0, 1, 32'h1000, 0, 0);
    add_vec(0, 0, 0, 1, 32'h1000, 0, 0);
    add_vec(0, 0, 1, 1, 32'h1000, 0, 0);
    add_vec(0, 0, 1, 0, 0,        0, 0);
    add_vec(0, 0, 1, 1, 32'h1004, 1, 32'h1000);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      apply_stimulus(vecs[i].st, vecs[i].rdy, 0, 0);
      check_output($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_addr,
                   vecs[i].exp_iv, vecs[i].exp_pc);
      end_cycle();
    end

    // redirect in WAIT with one entry buffered and a slow response
    do_reset();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    mem_lat = 3;
    apply_stimulus(1, 1, 0, 0); check_output("rd1_c2", 1, 32'h1004, 1, 32'h1000); end_cycle();
    apply_stimulus(1, 1, 1, 32'h2003); check_output("rd1_c3", 0, 0, 1, 32'h1000); end_cycle();
    apply_stimulus(0, 1, 0, 0); check_output("rd1_flush", 0, 0, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0);
    check_val("rd1_late_rsp", {31'b0, imem_rsp_valid}, 32'h1);
    check_output("rd1_drain", 0, 0, 0, 0); end_cycle();
    mem_lat = 1;
    apply_stimulus(0, 1, 0, 0); check_output("rd1_newreq", 1, 32'h2000, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); check_output("rd1_wait", 0, 0, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); check_output("rd1_first", 1, 32'h2004, 1, 32'h2000); end_cycle();

    // redirect coinciding with a response and a decode pop
    do_reset();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    apply_stimulus(0, 1, 1, 32'h3000);
    check_val("rd2_rsp", {31'b0, imem_rsp_valid}, 32'h1);
    check_output("rd2_pre", 0, 0, 1, 32'h1000); end_cycle();
    apply_stimulus(0, 1, 0, 0); check_output("rd2_idle", 1, 32'h3000, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); check_output("rd2_first", 1, 32'h3004, 1, 32'h3000); end_cycle();

    // asynchronous reset mid-WAIT, stale response after release
    do_reset();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    apply_stimulus(1, 1, 0, 0); end_cycle();
    mem_lat = 3;
    apply_stimulus(1, 1, 0, 0); end_cycle();
    apply_stimulus(1, 1, 0, 0);
    check_output("ar_pre", 0, 0, 1, 32'h1000);
    #1 reset = 1'b0;
    #1;
    check_val("ar_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_val("ar_if_valid", {31'b0, if_valid}, 32'h0);
    check_val("ar_if_pc", if_pc, 32'h0);
    check_val("ar_if_instr", if_instruction, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    mem_timer = 0;
    mem_lat = 1;
    apply_stimulus(0, 0, 0, 0);
    check_val("ar_stale_rsp", {31'b0, imem_rsp_valid}, 32'h1);
    check_output("ar_restart", 1, 32'h1000, 0, 0); end_cycle();
    apply_stimulus(0, 0, 0, 0); check_output("ar_ignored", 1, 32'h1000, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); end_cycle();
    apply_stimulus(0, 1, 0, 0); check_output("ar_first", 1, 32'h1004, 1, 32'h1000); end_cycle();

    // randomized run against the stream model
    do_reset();
    model_on  = 1;
    exp_fetch = 32'h1000;
    exp_del   = 32'h1000;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 4, $urandom);
      end_cycle();
    end
    model_on = 0;
    check_val("liveness", {31'b0, delivered > 100}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
